csr_timer_bank: RTL and testbench
=================================

CSR_TIMER_BANK -- requirements
Module: csr_timer_bank

Interface
REQ-001 SHALL have parameter NUM_TIMERS, default 2, meaning the number of independent countdown channels (legal range 1..8).
REQ-002 SHALL have parameter CSR_BASE, default 14'h41, meaning the CSR number of channel 0 TCFG.
REQ-003 SHALL have parameter RST_CNT, default 32'hFFFF_FFFF, meaning the counter value loaded at reset.
REQ-004 SHALL have port clk  input  1  as its single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  as reset, asynchronous and active-high.
REQ-006 SHALL have port csr_num  input  14  as the CSR address.
REQ-007 SHALL have port csr_we  input  1  as the write enable.
REQ-008 SHALL have port csr_wmask  input  32  as the per-bit write mask.
REQ-009 SHALL have port csr_wvalue  input  32  as the write data.
REQ-010 SHALL have port csr_rvalue  output  32  as the combinational read data.
REQ-011 SHALL have port timer_irq  output  NUM_TIMERS  as the per-channel pending interrupt.
REQ-012 SHALL have port stable_cnt  output  64  as a free-running cycle counter.

Function
REQ-013 SHALL map each channel i at three CSRs: TCFG at CSR_BASE+3i, TVAL at CSR_BASE+3i+1 (read-only), and TICLR at CSR_BASE+3i+2 (write-only; reads return 0).
REQ-014 SHALL lay out TCFG as bit0 EN, bit1 PERIODIC, bits[3:2] PSEL (prescale 1/2/4/8) and bits[31:4] INITV; the read value returns all fields.
REQ-015 SHALL compute every masked write as new = wmask&wvalue | ~wmask&old, and SHALL ignore writes to TVAL and to unmapped numbers.
REQ-016 SHALL give each channel three states: IDLE, RUN and EXPIRED.
REQ-017 SHALL, on a TCFG write whose post-mask EN=1, load the counter with {INITV_new,4'b0}, clear the prescaler and enter RUN the next cycle, including when the channel is already in RUN or EXPIRED.
REQ-018 SHALL, on a TCFG write whose post-mask EN=0, enter IDLE and freeze the counter and prescaler.
REQ-019 SHALL in RUN generate a tick every 2^PSEL cycles from a per-channel prescaler; without a tick the counter holds.
REQ-020 SHALL, on a tick in RUN with counter != 0, decrement the counter by 1.
REQ-021 SHALL, on a tick in RUN with counter == 0, set the pending bit; if PERIODIC it SHALL reload {INITV,4'b0} and stay in RUN, otherwise it SHALL hold 0 and enter EXPIRED (no wrap).
REQ-022 SHALL return the live counter value on a TVAL read.
REQ-023 SHALL clear pending on a TICLR write with wmask[0]&wvalue[0]=1; when a set and a clear occur in the same cycle, the set wins.
REQ-024 SHALL drive timer_irq[i] directly from channel i pending, registered with no extra latency beyond the setting edge.
REQ-025 SHALL increment stable_cnt by 1 every cycle, wrapping 2^64-1 to 0.
REQ-026 SHALL keep channels fully independent; a write to one channel SHALL NOT affect another.

Reset
REQ-027 SHALL force, while rst=1 (asynchronous), all channels to IDLE, TCFG to 0, counters to RST_CNT, prescalers to 0, pending and timer_irq to 0, and stable_cnt to 0.
REQ-028 SHALL, when rst asserts mid-count, abort the count immediately without setting pending; after release all channels stay IDLE until TCFG is written.

Verification
REQ-029 SHALL cover a one-shot case: ch0 TCFG=32'h0000_0021 (INITV=2, PSEL=0, EN=1) gives TVAL 32,31,...,0; pending sets on the next edge, the state is EXPIRED, and TVAL holds 0.
REQ-030 SHALL cover a periodic prescaled case: ch1 TCFG=32'h0000_001B (INITV=1, PSEL=2, PERIODIC, EN=1) decrements TVAL once every 4 cycles, irq fires every 17 ticks (68 cycles), and the counter reloads to 16.
REQ-031 SHALL cover clear vs. set: TICLR bit0 written on the same cycle as expiry leaves pending=1; the same write one cycle later gives pending=0.
REQ-032 SHALL cover a masked write: wmask=32'h1 with wvalue=0 on a running channel gives EN=0, INITV unchanged, and TVAL frozen.
REQ-033 SHALL cover reset mid-count: rst pulsed while ch0 TVAL=10 gives, with no clock edge, TVAL=32'hFFFF_FFFF, irq=0 and stable_cnt=0.
REQ-034 SHALL cover an unmapped read: csr_num=CSR_BASE+3*NUM_TIMERS returns 0 and writes to it change no state.

Source files
------------

// File: rtl/csr_timer_bank.sv
// Bank of CSR-mapped countdown timers with per-channel prescaler, one-shot or
// periodic mode, sticky pending interrupt, plus a free-running 64-bit cycle counter.
module csr_timer_bank #(
   parameter int unsigned NUM_TIMERS = 2,
   parameter logic [13:0] CSR_BASE   = 14'h41,
   parameter logic [31:0] RST_CNT    = 32'hFFFF_FFFF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [13:0]           csr_num,
   input  logic                  csr_we,
   input  logic [31:0]           csr_wmask,
   input  logic [31:0]           csr_wvalue,
   output logic [31:0]           csr_rvalue,
   output logic [NUM_TIMERS-1:0] timer_irq,
   output logic [63:0]           stable_cnt
);

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 14;
   localparam int unsigned PW = 3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_EXPIRED = 2'd2
   } state_t;

   logic [DW-1:0] rd_val [NUM_TIMERS];

   for (genvar i = 0; i < int'(NUM_TIMERS); i++) begin : g_ch
      localparam logic [AW-1:0] A_CFG = CSR_BASE + AW'(3 * i);
      localparam logic [AW-1:0] A_VAL = A_CFG + AW'(1);
      localparam logic [AW-1:0] A_CLR = A_CFG + AW'(2);

      state_t        state_q, state_d;
      logic [DW-1:0] tcfg_q, tcfg_d, cnt_q, cnt_d, wnew, reload;
      logic [PW-1:0] presc_q, presc_d, presc_max;
      logic          pend_q, pend_d;
      logic          cfg_we, clr, tick, expire;

      assign cfg_we    = csr_we && (csr_num == A_CFG);
      assign clr       = csr_we && (csr_num == A_CLR) && csr_wmask[0] && csr_wvalue[0];
      assign wnew      = (csr_wmask & csr_wvalue) | (~csr_wmask & tcfg_q);
      assign reload    = {tcfg_q[DW-1:4], 4'b0000};
      assign rd_val[i] = (csr_num == A_CFG) ? tcfg_q :
                         (csr_num == A_VAL) ? cnt_q  : '0;
      assign timer_irq[i] = pend_q;

      // Channel state register
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= S_IDLE;
            tcfg_q  <= '0;
            cnt_q   <= RST_CNT;
            presc_q <= '0;
            pend_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            tcfg_q  <= tcfg_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            pend_q  <= pend_d;
         end
      end

      // Next state: count, expire, then CSR writes override the counting path
      always_comb begin
         state_d   = state_q;
         tcfg_d    = tcfg_q;
         cnt_d     = cnt_q;
         presc_d   = presc_q;
         pend_d    = pend_q;
         tick      = 1'b0;
         expire    = 1'b0;
         presc_max = PW'(7);
         case (tcfg_q[3:2])
            2'd0:    presc_max = PW'(0);
            2'd1:    presc_max = PW'(1);
            2'd2:    presc_max = PW'(3);
            default: presc_max = PW'(7);
         endcase

         if (state_q == S_RUN) begin
            tick    = (presc_q == presc_max);
            presc_d = tick ? PW'(0) : presc_q + PW'(1);
            if (tick) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - DW'(1);
               end else begin
                  expire = 1'b1;
                  if (tcfg_q[1]) cnt_d   = reload;
                  else           state_d = S_EXPIRED;
               end
            end
         end

         // Set beats clear when both land on the same edge
         if (clr)    pend_d = 1'b0;
         if (expire) pend_d = 1'b1;

         if (cfg_we) begin
            tcfg_d = wnew;
            if (wnew[0]) begin
               state_d = S_RUN;
               cnt_d   = {wnew[DW-1:4], 4'b0000};
               presc_d = '0;
            end else begin
               state_d = S_IDLE;
               cnt_d   = cnt_q;
               presc_d = presc_q;
            end
         end
      end
   end

   // Only the addressed channel contributes a nonzero read value
   always_comb begin
      csr_rvalue = '0;
      for (int k = 0; k < int'(NUM_TIMERS); k++) begin
         csr_rvalue = csr_rvalue | rd_val[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stable_cnt <= '0;
      else     stable_cnt <= stable_cnt + 64'd1;
   end

endmodule

// File: tb/tb_csr_timer_bank.sv
// Scoreboard bench for csr_timer_bank: expectations are queued as stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_csr_timer_bank;

   localparam int unsigned NT   = 2;
   localparam logic [13:0] BASE = 14'h41;

   logic          clk = 1'b0;
   logic          rst;
   logic [13:0]   csr_num;
   logic          csr_we;
   logic [31:0]   csr_wmask;
   logic [31:0]   csr_wvalue;
   logic [31:0]   csr_rvalue;
   logic [NT-1:0] timer_irq;
   logic [63:0]   stable_cnt;

   typedef struct {
      string       name;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   csr_timer_bank #(.NUM_TIMERS(NT), .CSR_BASE(BASE), .RST_CNT(32'hFFFF_FFFF)) dut (
      .clk        (clk),
      .rst        (rst),
      .csr_num    (csr_num),
      .csr_we     (csr_we),
      .csr_wmask  (csr_wmask),
      .csr_wvalue (csr_wvalue),
      .csr_rvalue (csr_rvalue),
      .timer_irq  (timer_irq),
      .stable_cnt (stable_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   // Write lands on the next rising edge; returns at the following falling edge
   task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
      csr_num    = num;
      csr_wmask  = mask;
      csr_wvalue = val;
      csr_we     = 1'b1;
      @(negedge clk);
      csr_we     = 1'b0;
      csr_wmask  = '0;
      csr_wvalue = '0;
   endtask

   task automatic rd(input logic [13:0] num, output logic [63:0] v);
      csr_num = num;
      #1;
      v = 64'(csr_rvalue);
   endtask

   task automatic test_reset();
      exp_t e;
      logic [63:0] obs;
      sb.push_back('{"rst_tval0", 64'hFFFF_FFFF});
      sb.push_back('{"rst_tcfg0", 64'h0});
      sb.push_back('{"rst_tval1", 64'hFFFF_FFFF});
      sb.push_back('{"rst_irq", 64'h0});
      sb.push_back('{"rst_stable", 64'h0});
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: rd(BASE + 14'd1, obs);
            1: rd(BASE, obs);
            2: rd(BASE + 14'd4, obs);
            3: obs = 64'(timer_irq);
            default: obs = stable_cnt;
         endcase
         e = sb.pop_front();
         n_tests++;
         if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         end
      end
   endtask

   task automatic test_oneshot();
      exp_t e;
      logic [63:0] obs;
      wr(BASE, 32'hFFFF_FFFF, 32'h0000_0021);
      sb.push_back('{"oneshot_tcfg", 64'h21});
      rd(BASE, obs);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
      for (int k = 0; k < 37; k++) begin
         sb.push_back('{"oneshot_tval", (k <= 32) ? 64'(32 - k) : 64'h0});
         sb.push_back('{"oneshot_irq", (k >= 33) ? 64'h1 : 64'h0});
         rd(BASE + 14'd1, obs);
         e = sb.pop_front();
         n_tests++;
         if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s k=%0d: got %h expected %h", e.name, k, obs, e.val);
         end
         obs = 64'(timer_irq[0]);
         e = sb.pop_front();
         n_tests++;
         if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s k=%0d: got %h expected %h", e.name, k, obs, e.val);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_clear_vs_set();
      exp_t e;
      logic [63:0] obs;
      wr(BASE + 14'd2, 32'h1, 32'h1);
      sb.push_back('{"clr_plain_irq", 64'h0});
      obs = 64'(timer_irq[0]);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
      // Load zero so expiry falls on the very next edge, together with the clear
      wr(BASE, 32'hFFFF_FFFF, 32'h1);
      wr(BASE + 14'd2, 32'h1, 32'h1);
      sb.push_back('{"clr_same_edge_irq", 64'h1});
      sb.push_back('{"clr_same_edge_tval", 64'h0});
      obs = 64'(timer_irq[0]);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
      rd(BASE + 14'd1, obs);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
      wr(BASE + 14'd2, 32'h1, 32'h1);
      wr(BASE, 32'hFFFF_FFFF, 32'h1);
      @(negedge clk);
      sb.push_back('{"clr_before_irq", 64'h1});
      obs = 64'(timer_irq[0]);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
      wr(BASE + 14'd2, 32'h1, 32'h1);
      sb.push_back('{"clr_late_irq", 64'h0});
      obs = 64'(timer_irq[0]);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
   endtask

   task automatic test_periodic();
      exp_t e;
      logic [63:0] obs;
      wr(BASE + 14'd3, 32'hFFFF_FFFF, 32'h0000_001B);
      for (int k = 0; k < 140; k++) begin
         sb.push_back('{"periodic_tval", 64'(16 - ((k / 4) % 17))});
         sb.push_back('{"periodic_irq1", (k >= 68) ? 64'h1 : 64'h0});
         sb.push_back('{"periodic_irq0", 64'h0});
         for (int j = 0; j < 3; j++) begin
            case (j)
               0: rd(BASE + 14'd4, obs);
               1: obs = 64'(timer_irq[1]);
               default: obs = 64'(timer_irq[0]);
            endcase
            e = sb.pop_front();
            n_tests++;
            if (obs !== e.val) begin
               n_fail++;
               $display("FAIL %s k=%0d: got %h expected %h", e.name, k, obs, e.val);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_masked_write();
      exp_t e;
      logic [63:0] obs;
      wr(BASE + 14'd5, 32'h1, 32'h1);
      wr(BASE + 14'd3, 32'hFFFF_FFFF, 32'h0000_0011);
      repeat (3) @(negedge clk);
      // EN cleared on the same edge a tick would have taken 13 down to 12
      wr(BASE + 14'd3, 32'h1, 32'h0);
      sb.push_back('{"mask_tcfg", 64'h10});
      rd(BASE + 14'd3, obs);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
      for (int k = 0; k < 6; k++) begin
         sb.push_back('{"mask_tval_frozen", 64'd13});
         rd(BASE + 14'd4, obs);
         e = sb.pop_front();
         n_tests++;
         if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s k=%0d: got %h expected %h", e.name, k, obs, e.val);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_unmapped();
      exp_t e;
      logic [63:0] obs;
      logic [13:0] addr [9];
      sb.push_back('{"unmapped_read", 64'h0});
      sb.push_back('{"below_base_read", 64'h0});
      sb.push_back('{"ticlr0_read", 64'h0});
      addr[0] = BASE + 14'd6;
      addr[1] = BASE - 14'd1;
      addr[2] = BASE + 14'd2;
      for (int k = 0; k < 3; k++) begin
         rd(addr[k], obs);
         e = sb.pop_front();
         n_tests++;
         if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         end
      end
      wr(BASE + 14'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wr(BASE + 14'd1, 32'hFFFF_FFFF, 32'h1234_5678);
      wr(BASE + 14'd4, 32'hFFFF_FFFF, 32'h1234_5678);
      sb.push_back('{"after_unmapped_tcfg0", 64'h1});
      sb.push_back('{"after_unmapped_tval0", 64'h0});
      sb.push_back('{"after_unmapped_tcfg1", 64'h10});
      sb.push_back('{"after_unmapped_tval1", 64'd13});
      addr[3] = BASE;
      addr[4] = BASE + 14'd1;
      addr[5] = BASE + 14'd3;
      addr[6] = BASE + 14'd4;
      for (int k = 3; k < 7; k++) begin
         rd(addr[k], obs);
         e = sb.pop_front();
         n_tests++;
         if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         end
      end
      sb.push_back('{"after_unmapped_irq", 64'h0});
      obs = 64'(timer_irq);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
   endtask

   task automatic test_reset_midcount();
      exp_t e;
      logic [63:0] obs;
      wr(BASE, 32'hFFFF_FFFF, 32'h0000_0011);
      repeat (6) @(negedge clk);
      sb.push_back('{"mid_tval_before", 64'd10});
      sb.push_back('{"mid_tval_in_rst", 64'hFFFF_FFFF});
      sb.push_back('{"mid_irq_in_rst", 64'h0});
      sb.push_back('{"mid_stable_in_rst", 64'h0});
      sb.push_back('{"mid_tcfg_in_rst", 64'h0});
      rd(BASE + 14'd1, obs);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
      rst = 1'b1;
      #1;
      for (int j = 0; j < 3; j++) begin
         case (j)
            0: obs = 64'(csr_rvalue);
            1: obs = 64'(timer_irq);
            default: obs = stable_cnt;
         endcase
         e = sb.pop_front();
         n_tests++;
         if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         end
      end
      rd(BASE, obs);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
      end
      rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         sb.push_back('{"post_rst_tval0", 64'hFFFF_FFFF});
         sb.push_back('{"post_rst_tval1", 64'hFFFF_FFFF});
         sb.push_back('{"post_rst_irq", 64'h0});
         sb.push_back('{"post_rst_stable", 64'(k)});
         for (int j = 0; j < 4; j++) begin
            case (j)
               0: rd(BASE + 14'd1, obs);
               1: rd(BASE + 14'd4, obs);
               2: obs = 64'(timer_irq);
               default: obs = stable_cnt;
            endcase
            e = sb.pop_front();
            n_tests++;
            if (obs !== e.val) begin
               n_fail++;
               $display("FAIL %s k=%0d: got %h expected %h", e.name, k, obs, e.val);
            end
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      csr_num    = '0;
      csr_we     = 1'b0;
      csr_wmask  = '0;
      csr_wvalue = '0;
      #1;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_oneshot();
      test_clear_vs_set();
      test_periodic();
      test_masked_write();
      test_unmapped();
      test_reset_midcount();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
